// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit processor; define CU_RETIRE_CNT_EN to add retired_cnt
module multicycle_control_unit #(
  parameter int OPCODE_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                ir_load,
  output logic                pc_en,
  output logic [1:0]          pc_sel,
  output logic                sign_ex,
  output logic                mux_a,
  output logic                mux_b,
  output logic [1:0]          alu_ctrl,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                mem_req,
  output logic                mem_we,
  output logic                halted,
  output logic                illegal_op,
  output logic [2:0]          state
`ifdef CU_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]    retired_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} st_t;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_ADDI = 3'd2, OP_LD = 3'd3;
  localparam logic [2:0] OP_ST = 3'd4, OP_BEQ = 3'd5, OP_JMP = 3'd6, OP_HALT = 3'd7;
  st_t st, nxt;
  logic [2:0] op_q;
  logic legal, alu_phase;
  // Opcode legality (upper bits zero) and the retire-boundary destination chosen by run
  always_comb begin
    legal = (opcode >> 3) == '0;
    nxt = run ? FETCH : IDLE;
    alu_phase = st == EXEC || st == MEM;
  end
  // Sequencer: state and latched opcode, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      op_q <= '0;
    end else
      case (st)
        IDLE:    if (run) st <= FETCH;
        FETCH:   if (mem_ready) st <= DECODE;
        DECODE: begin
          op_q <= opcode[2:0];
          st <= !legal ? nxt : opcode[2:0] == OP_HALT ? HALT : EXEC;
        end
        EXEC:    st <= op_q inside {OP_ADD, OP_SUB, OP_ADDI} ? WB : op_q inside {OP_LD, OP_ST} ? MEM : nxt;
        MEM:     if (mem_ready) st <= op_q == OP_LD ? WB : nxt;
        WB:      st <= nxt;
        HALT:    st <= HALT;
        default: st <= IDLE;
      endcase
  // Control outputs from the state register; ALU operand/op selects stay stable through MEM for the address
  always_comb begin
    ir_load = st == FETCH && mem_ready;
    pc_en = (st == FETCH && mem_ready) || (st == EXEC && (op_q == OP_JMP || (op_q == OP_BEQ && alu_zero)));
    pc_sel = st != EXEC ? 2'b00 : op_q == OP_BEQ ? 2'b01 : op_q == OP_JMP ? 2'b10 : 2'b00;
    sign_ex = alu_phase && op_q inside {OP_ADDI, OP_LD, OP_ST, OP_BEQ};
    mux_a = st == EXEC && op_q == OP_BEQ;
    mux_b = alu_phase && op_q inside {OP_ADDI, OP_LD, OP_ST};
    alu_ctrl = alu_phase && op_q inside {OP_SUB, OP_BEQ} ? 2'b01 : 2'b00;
    reg_write = st == WB;
    mem_to_reg = st == WB && op_q == OP_LD;
    mem_req = st == FETCH || st == MEM;
    mem_we = st == MEM && op_q == OP_ST;
    halted = st == HALT;
    illegal_op = st == DECODE && !legal;
    state = st;
  end
`ifdef CU_RETIRE_CNT_EN
  logic retire;
  // An instruction retires when it leaves the FSM for FETCH/IDLE; HALT never retires
  always_comb
    retire = (st == DECODE && !legal) || (st == EXEC && op_q inside {OP_BEQ, OP_JMP}) ||
             (st == MEM && op_q == OP_ST && mem_ready) || st == WB;
  // Wrapping retired-instruction counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) retired_cnt <= '0;
    else if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
`endif
endmodule
